// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry: 4x4 active-low matrix keypad scanner with debouncing and a
// decimal operand accumulator. The live operand drives the display path. A committed
// operand is offered to the processor core over a valid/ack handshake.
module keypad_scan_entry #(
    parameter int SCAN_DIV       = 100000,  // clocks per column slot, must be >= 2
    parameter int DEBOUNCE_SCANS = 4,       // stable full scans to accept a press or release
    parameter int MAX_DIGITS     = 4        // decimal digits kept in the accumulator
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_drive,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [15:0] acc_value,
    output logic [2:0]  digit_count,
    output logic [15:0] entry_value,
    output logic        entry_valid,
    input  logic        entry_ack
);

    localparam int                SLOT_W     = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam int                CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [2:0]        DIGITS_MAX = 3'(MAX_DIGITS);

    localparam logic [3:0] CODE_STAR = 4'hE;
    localparam logic [3:0] CODE_HASH = 4'hF;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} scan_res_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_WAIT_RELEASE} deb_state_t;

    // Physical key position to key code: r0: 1 2 3 A, r1: 4 5 6 B, r2: 7 8 9 C, r3: * 0 # D.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;   4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;   4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;   4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;   4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;   4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;   4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;   4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;   default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0]        row_meta, row_sync;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [1:0]        hit_acc;     // hits so far this scan: 0, 1, or 2 meaning "more than one"
    logic [3:0]        code_acc;
    logic [1:0]        col_hits;
    logic [1:0]        row_sel;
    logic [2:0]        hit_sum;
    logic [1:0]        hits_total;
    logic [3:0]        code_total;
    logic              slot_end, scan_done;
    scan_res_t         scan_res, prev_res;
    logic [3:0]        prev_code;
    deb_state_t        state;
    logic [CNT_W-1:0]  stab_cnt, rel_cnt, stab_next, rel_next;

    // Two-flop synchronizer for the asynchronous keypad rows.
    // NOTE: sync flops reset to all-ones (no row pulled low) so reset never looks like a press.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments keep both stages sampling the pre-edge values.
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Decode the active column and merge it with the hits collected earlier in this scan.
    always_comb begin
        col_hits = 2'd0;
        row_sel  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                row_sel  = 2'(r);
                col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
        hit_sum    = {1'b0, hit_acc} + {1'b0, col_hits};
        hits_total = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        code_total = (col_hits == 2'd1) ? key_map(row_sel, col_idx) : code_acc;
        slot_end   = (slot_cnt == SLOT_LAST);
        scan_done  = slot_end && (col_idx == 2'd3);
        case (hits_total)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_KEY;
            default: scan_res = RES_MULTI;
        endcase
    end

    // Slot timer and column walker; accumulates hits across the four columns of a scan.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            col_idx   <= 2'd0;
            col_drive <= 4'b1110;
            hit_acc   <= 2'd0;
            code_acc  <= 4'd0;
        end else if (slot_end) begin
            slot_cnt  <= '0;
            col_idx   <= col_idx + 2'd1;
            col_drive <= {col_drive[2:0], col_drive[3]};
            if (col_idx == 2'd3) begin
                hit_acc  <= 2'd0;
                code_acc <= 4'd0;
            end else begin
                hit_acc  <= hits_total;
                code_acc <= code_total;
            end
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Next debounce counts for the scan completing this cycle.
    always_comb begin
        stab_next = '0;
        if (scan_res == RES_KEY) begin
            stab_next = (prev_res == RES_KEY && prev_code == code_total) ?
                        stab_cnt + CNT_W'(1) : CNT_W'(1);
        end
        rel_next = (scan_res == RES_NONE) ? rel_cnt + CNT_W'(1) : '0;
    end

    // Debounce FSM: one strobe per stable press, then wait for a stable release.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state      <= ST_WAIT_RELEASE;
            stab_cnt   <= '0;
            rel_cnt    <= '0;
            prev_res   <= RES_NONE;
            prev_code  <= 4'd0;
            key_code   <= 4'd0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (scan_done) begin
                prev_res  <= scan_res;
                prev_code <= code_total;
                case (state)
                    ST_IDLE: begin
                        if (stab_next == CNT_DONE) begin
                            key_code   <= code_total;
                            key_strobe <= 1'b1;
                            state      <= ST_PRESSED;
                            stab_cnt   <= '0;
                            rel_cnt    <= '0;
                        end else begin
                            stab_cnt <= stab_next;
                        end
                    end
                    ST_PRESSED, ST_WAIT_RELEASE: begin
                        if (rel_next == CNT_DONE) begin
                            state    <= ST_IDLE;
                            rel_cnt  <= '0;
                            stab_cnt <= '0;
                        end else begin
                            rel_cnt <= rel_next;
                        end
                    end
                    default: state <= ST_WAIT_RELEASE;
                endcase
            end
        end
    end

    // Operand entry and commit handshake, acting on the cycle after each key strobe.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            acc_value   <= 16'd0;
            digit_count <= 3'd0;
            entry_value <= 16'd0;
            entry_valid <= 1'b0;
        end else begin
            if (entry_ack) begin
                entry_valid <= 1'b0;
            end
            if (key_strobe) begin
                if (key_code <= 4'd9) begin
                    if (digit_count < DIGITS_MAX) begin
                        acc_value   <= acc_value * 16'd10 + {12'd0, key_code};
                        digit_count <= digit_count + 3'd1;
                    end
                end else if (key_code == CODE_STAR) begin
                    acc_value   <= 16'd0;
                    digit_count <= 3'd0;
                end else if (key_code == CODE_HASH && digit_count != 3'd0 && !entry_valid) begin
                    entry_value <= acc_value;
                    entry_valid <= 1'b1;
                    acc_value   <= 16'd0;
                    digit_count <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// tb_keypad_scan_entry: directed bench for keypad_scan_entry with short scan timing.
module tb_keypad_scan_entry;

    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic [15:0] acc_value;
    logic [2:0]  digit_count;
    logic [15:0] entry_value;
    logic        entry_valid;
    logic        entry_ack;

    logic [15:0] pressed;       // physical key matrix, bit r*4+c set while held
    int          n_cmp = 0;
    int          n_bad = 0;
    int          strobe_cnt = 0;
    logic [3:0]  last_code = 4'd0;

    keypad_scan_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .MAX_DIGITS(4)) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .row_in     (row_in),
        .col_drive  (col_drive),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .acc_value  (acc_value),
        .digit_count(digit_count),
        .entry_value(entry_value),
        .entry_valid(entry_valid),
        .entry_ack  (entry_ack)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Keypad model: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_drive[c]) row_in[r] = 1'b0;
    end

    // Count strobes and remember the code each one carried.
    always @(negedge clk_100mhz) begin
        if (key_strobe === 1'b1) begin
            strobe_cnt++;
            last_code = key_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int key_pos(input logic [3:0] code);
        case (code)
            4'h1: key_pos = 0;   4'h2: key_pos = 1;   4'h3: key_pos = 2;   4'hA: key_pos = 3;
            4'h4: key_pos = 4;   4'h5: key_pos = 5;   4'h6: key_pos = 6;   4'hB: key_pos = 7;
            4'h7: key_pos = 8;   4'h8: key_pos = 9;   4'h9: key_pos = 10;  4'hC: key_pos = 11;
            4'hE: key_pos = 12;  4'h0: key_pos = 13;  4'hF: key_pos = 14;  default: key_pos = 15;
        endcase
    endfunction

    // Press one key, expect exactly one strobe with its code, then release it cleanly.
    task automatic tap(input logic [3:0] code);
        int s0;
        int n;
        s0 = strobe_cnt;
        pressed = 16'd1 << key_pos(code);
        n = 0;
        while (strobe_cnt == s0 && n < 200) begin
            @(negedge clk_100mhz);
            #1;
            n++;
        end
        repeat (40) @(negedge clk_100mhz);
        check($sformatf("strobes_key_%h", code), strobe_cnt - s0, 1);
        check($sformatf("code_key_%h", code), last_code, code);
        pressed = 16'd0;
        repeat (64) @(negedge clk_100mhz);
    endtask

    task automatic pulse_ack();
        @(negedge clk_100mhz);
        entry_ack = 1'b1;
        @(negedge clk_100mhz);
        entry_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [3:0] exp_col;
        int         n;
        reset     = 1'b1;
        entry_ack = 1'b0;
        pressed   = 16'd0;
        repeat (3) @(negedge clk_100mhz);

        // Reset values.
        check("rst_col_drive", col_drive, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_strobe", key_strobe, 0);
        check("rst_acc_value", acc_value, 0);
        check("rst_digit_count", digit_count, 0);
        check("rst_entry_value", entry_value, 0);
        check("rst_entry_valid", entry_valid, 0);

        // 1: column rotation every 4 clocks, and no strobe with rows idle.
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_100mhz);
            exp_col = 4'hF;
            exp_col[(i / 4) % 4] = 1'b0;
            check($sformatf("col_drive_cyc%0d", i), col_drive, exp_col);
        end
        repeat (1000) @(negedge clk_100mhz);
        check("idle_no_strobe", strobe_cnt, 0);

        // 2: bouncy '5' press, single strobe, accumulator updates one cycle later.
        pressed = 16'h0020;
        #30 pressed = 16'h0000;
        #20 pressed = 16'h0020;
        #30 pressed = 16'h0000;
        #20 pressed = 16'h0020;
        n = 0;
        do begin
            @(negedge clk_100mhz);
            n++;
        end while (key_strobe !== 1'b1 && n < 200);
        check("t2_strobe_seen", key_strobe, 1);
        check("t2_key_code", key_code, 5);
        check("t2_acc_before", acc_value, 0);
        @(negedge clk_100mhz);
        check("t2_acc_after", acc_value, 5);
        check("t2_digits", digit_count, 1);
        repeat (60) @(negedge clk_100mhz);
        check("t2_one_strobe", strobe_cnt, 1);
        pressed = 16'd0;
        repeat (64) @(negedge clk_100mhz);

        // 3: clear, five digits (fifth ignored), commit, acknowledge.
        tap(4'hE);
        check("t3_clear_acc", acc_value, 0);
        tap(4'h1); tap(4'h2); tap(4'h3); tap(4'h4);
        check("t3_acc_1234", acc_value, 1234);
        check("t3_digits_4", digit_count, 4);
        tap(4'h5);
        check("t3_acc_5th_ignored", acc_value, 1234);
        check("t3_digits_still_4", digit_count, 4);
        tap(4'hF);
        check("t3_entry_value", entry_value, 1234);
        check("t3_entry_valid", entry_valid, 1);
        check("t3_acc_cleared", acc_value, 0);
        check("t3_digits_cleared", digit_count, 0);
        pulse_ack();
        check("t3_valid_after_ack", entry_valid, 0);
        tap(4'hF);
        check("t3_empty_hash_valid", entry_valid, 0);
        check("t3_empty_hash_value", entry_value, 1234);

        // 4: commit 42, then a second '#' while still valid must not commit.
        tap(4'h4); tap(4'h2); tap(4'hF);
        check("t4_entry_42", entry_value, 42);
        tap(4'h7);
        check("t4_acc_7", acc_value, 7);
        tap(4'hE); tap(4'h9);
        check("t4_acc_9", acc_value, 9);
        check("t4_digits_1", digit_count, 1);
        tap(4'hF);
        check("t4_blocked_value", entry_value, 42);
        check("t4_blocked_valid", entry_valid, 1);
        check("t4_acc_kept", acc_value, 9);
        check("t4_digits_kept", digit_count, 1);
        pulse_ack();
        check("t4_ack_valid", entry_valid, 0);
        pulse_ack();
        check("t4_stray_ack_valid", entry_valid, 0);
        check("t4_stray_ack_value", entry_value, 42);
        tap(4'hF);
        check("t4_commit_9", entry_value, 9);
        check("t4_commit_valid", entry_valid, 1);
        tap(4'hB);
        check("t4_letter_no_effect", acc_value, 0);

        // 5: '1' and '2' together give no strobe; releasing '2' accepts '1'.
        n = strobe_cnt;
        pressed = 16'h0003;
        repeat (150) @(negedge clk_100mhz);
        check("t5_multi_no_strobe", strobe_cnt - n, 0);
        pressed = 16'h0001;
        repeat (100) @(negedge clk_100mhz);
        check("t5_release_strobe", strobe_cnt - n, 1);
        check("t5_code_1", last_code, 1);
        check("t5_acc_1", acc_value, 1);
        pressed = 16'd0;
        repeat (64) @(negedge clk_100mhz);

        // 6: '8' held through reset never strobes; a fresh press does.
        check("t6_valid_pending", entry_valid, 1);
        pressed = 16'd1 << key_pos(4'h8);
        repeat (5) @(negedge clk_100mhz);
        #2 reset = 1'b1;
        #1;
        check("t6_async_col", col_drive, 4'b1110);
        check("t6_async_valid", entry_valid, 0);
        check("t6_async_acc", acc_value, 0);
        @(negedge clk_100mhz);
        reset = 1'b0;
        n = strobe_cnt;
        repeat (200) @(negedge clk_100mhz);
        check("t6_held_no_strobe", strobe_cnt - n, 0);
        pressed = 16'd0;
        repeat (64) @(negedge clk_100mhz);
        tap(4'h8);
        check("t6_acc_8", acc_value, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
